// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer for a shared one-layer 32-bit shifter: applies layers 16/8/4/2/1 on
// successive clocks, right-shift only, with bit reversal at entry/exit for left shifts.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    logic [1:0]       state;
    logic [2:0]       k;
    logic [WIDTH-1:0] work;
    logic [AMTW-1:0]  amt;
    logic [1:0]       mode;
    logic             sign;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // One physical layer: right shift by 2^k, with the upper half of the
    // concatenation supplying zero, sign or rotate fill.
    function automatic logic [WIDTH-1:0] shift_layer(input logic [WIDTH-1:0] w,
                                                     input logic [2:0]       kk,
                                                     input logic [1:0]       m,
                                                     input logic             s);
        logic [WIDTH-1:0]   fill;
        logic [2*WIDTH-1:0] ext;
        logic [AMTW:0]      sh;
        fill = (m == MODE_ROR) ? w : {WIDTH{(m == MODE_SRA) && s}};
        sh   = {{AMTW{1'b0}}, 1'b1} << kk;
        ext  = {fill, w} >> sh;
        return ext[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= 3'd0;
            work  <= '0;
            amt   <= '0;
            mode  <= 2'b00;
            sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= (in_mode == MODE_SLL) ? bit_reverse(in_data) : in_data;
                        amt   <= in_amt;
                        mode  <= in_mode;
                        sign  <= in_data[WIDTH-1];
                        k     <= 3'd4;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (amt[k]) begin
                        work <= shift_layer(work, k, mode, sign);
                    end
                    if (k == 3'd0) begin
                        state <= DONE;
                    end else begin
                        k <= k - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign out_data  = (state != DONE)     ? '0 :
                       (mode == MODE_SLL)  ? bit_reverse(work) : work;

endmodule
